psg_bus_sequencer: RTL and testbench

Turns single-cycle CPU port accesses into correctly phased BDIR/BC bus cycles for up to two ym2149 instances (TurboSound-style pair).
- Sits between the ZX81 I/O decode and the PSG instances.
- Queues writes in a small FIFO and serialises them into address-latch and data-write cycles.
- Services reads by issuing a read cycle once the queue has drained, then returning the captured byte.

---
 rtl/psg_bus_sequencer.sv | 179 +++++++++++++++++
 tb/tb_psg_bus_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_sequencer.sv
// Serialises CPU port accesses into BDIR/BC bus cycles for a pair of ym2149 chips.
// Writes are queued with their chip tag; reads wait for the queue to drain.
module psg_bus_sequencer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       cpu_wr_addr,
   input  logic       cpu_wr_data,
   input  logic       cpu_rd,
   input  logic [7:0] cpu_di,
   output logic [7:0] cpu_do,
   output logic       cpu_rd_valid,
   output logic       busy,
   output logic       err,
   output logic [1:0] psg_bdir,
   output logic [1:0] psg_bc,
   output logic [7:0] psg_di,
   input  logic [7:0] psg0_do,
   input  logic [7:0] psg1_do,
   output logic       chip_sel
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {StIdle, StAddr, StData, StRead, StGap} state_e;

   // Entry layout: [9] = 1 for address latch, [8] = chip, [7:0] = data.
   logic [9:0]    r_fifo [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   state_e        r_state;
   logic          r_cur_chip;
   logic          r_rd_pending;
   logic          r_rd_chip;
   logic          r_chip_sel;
   logic          r_busy;
   logic          r_err;
   logic          r_rd_valid;
   logic [7:0]    r_cpu_do;
   logic [7:0]    r_psg_di;

   state_e        w_state_nxt;
   logic [9:0]    w_head;
   logic          w_sel;
   logic          w_any_wr;
   logic          w_want_push;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_rd_done;
   logic          w_err_set;
   logic          w_bdir;
   logic          w_bc;
   logic [CW-1:0] w_count_nxt;
   logic          w_rd_pending_nxt;

   assign w_head      = r_fifo[r_rptr];
   assign w_sel       = cpu_wr_addr & ((cpu_di == 8'hFF) | (cpu_di == 8'hFE));
   assign w_any_wr    = cpu_wr_addr | cpu_wr_data;
   // A data write coinciding with an address write is always discarded.
   assign w_want_push = (cpu_wr_addr & ~w_sel) | (cpu_wr_data & ~cpu_wr_addr);
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_push      = w_want_push & ~w_full & ~r_rd_pending;
   assign w_err_set   = (cpu_wr_addr & cpu_wr_data) | (w_any_wr & r_rd_pending) |
                        (w_want_push & w_full) | (cpu_rd & r_rd_pending);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_rd_done   = 1'b0;
      w_bdir      = 1'b0;
      w_bc        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = w_head[9] ? StAddr : StData;
            end else if (r_rd_pending) begin
               w_state_nxt = StRead;
            end
         end
         StAddr: begin
            w_bdir      = 1'b1;
            w_bc        = 1'b1;
            w_state_nxt = StGap;
         end
         StData: begin
            w_bdir      = 1'b1;
            w_state_nxt = StGap;
         end
         StRead: begin
            w_bc        = 1'b1;
            w_rd_done   = 1'b1;
            w_state_nxt = StGap;
         end
         StGap:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
      w_rd_pending_nxt = r_rd_pending;
      if (w_rd_done) begin
         w_rd_pending_nxt = 1'b0;
      end else if (cpu_rd) begin
         w_rd_pending_nxt = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_fifo[r_wptr] <= {cpu_wr_addr, r_chip_sel, cpu_di};
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_state      <= StIdle;
         r_cur_chip   <= 1'b0;
         r_rd_pending <= 1'b0;
         r_rd_chip    <= 1'b0;
         r_chip_sel   <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_cpu_do     <= 8'hFF;
         r_psg_di     <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_rd_pending <= w_rd_pending_nxt;
         r_busy       <= w_rd_pending_nxt | (w_count_nxt == CW'(DEPTH));
         r_rd_valid   <= w_rd_done;
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr     <= r_rptr + AW'(1);
            r_psg_di   <= w_head[7:0];
            r_cur_chip <= w_head[8];
         end else if (r_state == StIdle && r_rd_pending) begin
            r_cur_chip <= r_rd_chip;
         end
         if (cpu_rd && !r_rd_pending) begin
            r_rd_chip <= r_chip_sel;
         end
         if (w_rd_done) begin
            r_cpu_do <= r_cur_chip ? psg1_do : psg0_do;
         end
         if (w_sel && !r_rd_pending) begin
            r_chip_sel <= (cpu_di == 8'hFE);
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign psg_bdir     = w_bdir ? (r_cur_chip ? 2'b10 : 2'b01) : 2'b00;
   assign psg_bc       = w_bc   ? (r_cur_chip ? 2'b10 : 2'b01) : 2'b00;
   assign psg_di       = r_psg_di;
   assign cpu_do       = r_cpu_do;
   assign cpu_rd_valid = r_rd_valid;
   assign busy         = r_busy;
   assign err          = r_err;
   assign chip_sel     = r_chip_sel;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Scoreboard bench: expected bus strobes and read results are queued as stimulus
// is driven and compared as the sequencer produces them.
module tb_psg_bus_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       cpu_wr_addr = 1'b0;
   logic       cpu_wr_data = 1'b0;
   logic       cpu_rd = 1'b0;
   logic [7:0] cpu_di = 8'h00;
   logic [7:0] cpu_do;
   logic       cpu_rd_valid;
   logic       busy;
   logic       err;
   logic [1:0] psg_bdir;
   logic [1:0] psg_bc;
   logic [7:0] psg_di;
   logic [7:0] psg0_do = 8'h5A;
   logic [7:0] psg1_do = 8'hA5;
   logic       chip_sel;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [11:0] exp_q[$];
   logic [7:0]  rdv_q[$];

   psg_bus_sequencer #(.DEPTH(4)) u_dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .cpu_wr_addr  (cpu_wr_addr),
      .cpu_wr_data  (cpu_wr_data),
      .cpu_rd       (cpu_rd),
      .cpu_di       (cpu_di),
      .cpu_do       (cpu_do),
      .cpu_rd_valid (cpu_rd_valid),
      .busy         (busy),
      .err          (err),
      .psg_bdir     (psg_bdir),
      .psg_bc       (psg_bc),
      .psg_di       (psg_di),
      .psg0_do      (psg0_do),
      .psg1_do      (psg1_do),
      .chip_sel     (chip_sel)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Event encoding: {bdir[1:0], bc[1:0], psg_di}.
   function automatic logic [11:0] ev(input logic chip, input logic bd, input logic bc,
                                      input logic [7:0] di);
      logic [1:0] m;
      m = chip ? 2'b10 : 2'b01;
      return {bd ? m : 2'b00, bc ? m : 2'b00, di};
   endfunction

   task automatic drive(input logic wa, input logic wd, input logic rd, input logic [7:0] di);
      @(negedge CLK);
      cpu_wr_addr = wa;
      cpu_wr_data = wd;
      cpu_rd      = rd;
      cpu_di      = di;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic monitor_loop();
      logic prev_strobe;
      logic [31:0] e;
      prev_strobe = 1'b0;
      forever begin
         @(negedge CLK);
         if (psg_bdir != 2'b00 || psg_bc != 2'b00) begin
            e = (exp_q.size() != 0) ? {20'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check_eq("strobe", {20'h0, psg_bdir, psg_bc, psg_di}, e);
            check_eq("gap_before_strobe", {31'h0, prev_strobe}, 32'h0);
            prev_strobe = 1'b1;
         end else begin
            prev_strobe = 1'b0;
         end
         if (cpu_rd_valid) begin
            e = (rdv_q.size() != 0) ? {24'h0, rdv_q.pop_front()} : 32'h100;
            check_eq("rd_data", {24'h0, cpu_do}, e);
         end
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && (exp_q.size() != 0 || rdv_q.size() != 0); i++) begin
         @(negedge CLK);
      end
      check_eq("drain", exp_q.size() + rdv_q.size(), 0);
      repeat (4) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET       = 1'b1;
      cpu_wr_addr = 1'b0;
      cpu_wr_data = 1'b0;
      cpu_rd      = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge CLK);
      check_eq("rst_bdir", {30'h0, psg_bdir}, 0);
      check_eq("rst_bc", {30'h0, psg_bc}, 0);
      check_eq("rst_di", {24'h0, psg_di}, 0);
      check_eq("rst_cpu_do", {24'h0, cpu_do}, 32'hFF);
      check_eq("rst_flags", {28'h0, cpu_rd_valid, busy, err, chip_sel}, 0);
      RESET = 1'b0;
      fork
         monitor_loop();
      join_none

      // 1: address then data on chip 0, with exact phase timing
      exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 8'h07));
      drive(1'b1, 1'b0, 1'b0, 8'h07);
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 8'h38));
      drive(1'b0, 1'b1, 1'b0, 8'h38);
      idle();
      check_eq("t1_addr_phase", {20'h0, psg_bdir, psg_bc, psg_di}, {20'h0, 4'b0101, 8'h07});
      @(negedge CLK);
      check_eq("t1_gap", {20'h0, psg_bdir, psg_bc, psg_di}, {20'h0, 4'b0000, 8'h07});
      repeat (2) @(negedge CLK);
      check_eq("t1_data_phase", {20'h0, psg_bdir, psg_bc, psg_di}, {20'h0, 4'b0100, 8'h38});
      wait_drain();
      check_eq("t1_err", {31'h0, err}, 0);

      // 2: select chip 1, then write to it
      drive(1'b1, 1'b0, 1'b0, 8'hFE);
      idle();
      check_eq("t2_chip_sel", {31'h0, chip_sel}, 1);
      exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 8'h08));
      drive(1'b1, 1'b0, 1'b0, 8'h08);
      exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 8'h0F));
      drive(1'b0, 1'b1, 1'b0, 8'h0F);
      idle();
      wait_drain();
      check_eq("t2_err", {31'h0, err}, 0);

      // 3: overrun; queue drains once per 3 cycles so 6 of 7 back-to-back writes fit
      for (int i = 0; i < 7; i++) begin
         if (i < 6) exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 8'h10 + 8'(i)));
         drive(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i));
         if (i == 6) check_eq("t3_busy_full", {31'h0, busy}, 1);
      end
      idle();
      wait_drain();
      check_eq("t3_err", {31'h0, err}, 1);
      check_eq("t3_busy_clear", {31'h0, busy}, 0);

      // 4: read after two writes on chip 0; write during pending read is dropped
      do_reset();
      check_eq("t4_err_cleared", {31'h0, err}, 0);
      exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 8'h01));
      drive(1'b1, 1'b0, 1'b0, 8'h01);
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 8'h22));
      drive(1'b0, 1'b1, 1'b0, 8'h22);
      exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 8'h22));
      rdv_q.push_back(8'h5A);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      idle();
      check_eq("t4_busy_pending", {31'h0, busy}, 1);
      drive(1'b0, 1'b1, 1'b0, 8'h99);
      idle();
      wait_drain();
      check_eq("t4_err", {31'h0, err}, 1);
      check_eq("t4_cpu_do", {24'h0, cpu_do}, 32'h5A);
      check_eq("t4_busy_done", {31'h0, busy}, 0);

      // 5: simultaneous address and data writes
      do_reset();
      exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 8'h03));
      drive(1'b1, 1'b1, 1'b0, 8'h03);
      idle();
      wait_drain();
      check_eq("t5_err", {31'h0, err}, 1);

      // 6: reset during a DATA phase with two entries still queued
      do_reset();
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 8'hA1));
      drive(1'b0, 1'b1, 1'b0, 8'hA1);
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 8'hA2));
      drive(1'b0, 1'b1, 1'b0, 8'hA2);
      drive(1'b0, 1'b1, 1'b0, 8'hA3);
      drive(1'b0, 1'b1, 1'b0, 8'hA4);
      idle();
      @(negedge CLK);
      check_eq("t6_in_data", {20'h0, psg_bdir, psg_bc, psg_di}, {20'h0, 4'b0100, 8'hA2});
      RESET = 1'b1;
      @(negedge CLK);
      check_eq("t6_bus", {28'h0, psg_bdir, psg_bc}, 0);
      check_eq("t6_busy", {31'h0, busy}, 0);
      check_eq("t6_cpu_do", {24'h0, cpu_do}, 32'hFF);
      check_eq("t6_di", {24'h0, psg_di}, 0);
      check_eq("t6_err", {31'h0, err}, 0);
      RESET = 1'b0;
      repeat (20) @(negedge CLK);
      check_eq("t6_no_more", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
